// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Detects read-after-write hazards between the instruction in ID and the
//   producer currently in EX, for a pipeline whose only forwarding path is
//   MEM/WB -> EX. A producer in EX cannot be forwarded to the very next
//   instruction, so the consumer is held in ID for one cycle while a bubble
//   is injected into ID/EX. Producers already in MEM are covered by the
//   forwarding unit and producers in WB are covered by the write-on-falling-
//   edge register file, so neither causes a stall.
//
//   Shadow entries EX, MEM and WB mirror {v, rd, wr, ld} of the in-flight
//   instructions. The ld flag is carried for observability only: loads and
//   ALU producers stall identically here.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 asynchronous active-low reset
//   IF_ID_RegisterRs1   rs1 of the instruction in ID
//   IF_ID_RegisterRs2   rs2 of the instruction in ID
//   IF_ID_RegisterRd    rd of the instruction in ID
//   ID_valid            ID holds a real instruction
//   ID_regWrite         ID instruction writes rd
//   ID_memRead          ID instruction is a load
//   ID_usesRs2          ID instruction reads rs2
//   flush               taken branch/jump this cycle; kills the ID instruction
//   hold                external freeze; whole pipeline frozen
//   PC_write            PC may update
//   IF_ID_write         IF/ID register may load
//   ID_EX_bubble        ID/EX loads a NOP
//   stall_count         saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_RegisterRs1,
  input  logic [4:0]  IF_ID_RegisterRs2,
  input  logic [4:0]  IF_ID_RegisterRd,
  input  logic        ID_valid,
  input  logic        ID_regWrite,
  input  logic        ID_memRead,
  input  logic        ID_usesRs2,
  input  logic        flush,
  input  logic        hold,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};

  // Shadow pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  localparam int unsigned EX_IDX  = 0;
  localparam int unsigned MEM_IDX = 1;
  localparam int unsigned WB_IDX  = 2;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  entry_t      shadow_r [0:2];
  entry_t      ex_next_s;
  logic [15:0] stall_count_r;

  logic        match_rs1_s;
  logic        match_rs2_s;
  logic        hazard_s;
  logic        stall_s;
  logic        issue_s;

  // A producer in EX blocks source s only if it really writes a non-x0 rd.
  function automatic logic ex_match(input entry_t e, input logic [4:0] s);
    return e.v & e.wr & (e.rd != 5'd0) & (e.rd == s);
  endfunction

  // Hazard detection, stall/issue decisions and pipeline control outputs.
  always_comb begin
    match_rs1_s  = 1'b0;
    match_rs2_s  = 1'b0;
    hazard_s     = 1'b0;
    stall_s      = 1'b0;
    issue_s      = 1'b0;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;

    match_rs1_s = ex_match(shadow_r[EX_IDX], IF_ID_RegisterRs1);
    match_rs2_s = ex_match(shadow_r[EX_IDX], IF_ID_RegisterRs2);
    hazard_s    = ID_valid & (match_rs1_s | (ID_usesRs2 & match_rs2_s));

    // flush wins over the hazard: the consumer is being killed anyway.
    stall_s = hazard_s & ~flush & ~hold;
    issue_s = ID_valid & ~stall_s & ~flush & ~hold;

    PC_write     = ~stall_s & ~hold;
    IF_ID_write  = ~stall_s & ~hold;
    ID_EX_bubble = (stall_s | flush) & ~hold;
  end

  // Destination info entering EX on the next edge: the issued instruction or a NOP.
  always_comb begin
    ex_next_s = ENTRY_EMPTY;
    if (issue_s) begin
      ex_next_s.v  = 1'b1;
      ex_next_s.rd = IF_ID_RegisterRd;
      ex_next_s.wr = ID_regWrite;
      ex_next_s.ld = ID_memRead;
    end else begin
      ex_next_s = ENTRY_EMPTY;
    end
  end

  // Shadow entry shift register; frozen while hold is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r[EX_IDX]  <= ENTRY_EMPTY;
      shadow_r[MEM_IDX] <= ENTRY_EMPTY;
      shadow_r[WB_IDX]  <= ENTRY_EMPTY;
    end else if (!hold) begin
      shadow_r[WB_IDX]  <= shadow_r[MEM_IDX];
      shadow_r[MEM_IDX] <= shadow_r[EX_IDX];
      shadow_r[EX_IDX]  <= ex_next_s;
    end else begin
      shadow_r[EX_IDX]  <= shadow_r[EX_IDX];
      shadow_r[MEM_IDX] <= shadow_r[MEM_IDX];
      shadow_r[WB_IDX]  <= shadow_r[WB_IDX];
    end
  end

  // Saturating stall-cycle counter; stall already implies hold is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_r <= 16'd0;
    end else if (stall_s && (stall_count_r != COUNT_MAX)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        id_valid;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_uses_rs2;
  logic        flush;
  logic        hold;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        v;
    logic        wr;
    logic        ld;
    logic        u2;
    logic        fl;
    logic        ho;
    logic        pc;
    logic        ifid;
    logic        bub;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vt [0:NVEC-1];

  hazard_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_RegisterRs1 (rs1),
    .IF_ID_RegisterRs2 (rs2),
    .IF_ID_RegisterRd  (rd),
    .ID_valid          (id_valid),
    .ID_regWrite       (id_reg_write),
    .ID_memRead        (id_mem_read),
    .ID_usesRs2        (id_uses_rs2),
    .flush             (flush),
    .hold              (hold),
    .PC_write          (pc_write),
    .IF_ID_write       (if_id_write),
    .ID_EX_bubble      (id_ex_bubble),
    .stall_count       (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rs1          = x.rs1;
    rs2          = x.rs2;
    rd           = x.rd;
    id_valid     = x.v;
    id_reg_write = x.wr;
    id_mem_read  = x.ld;
    id_uses_rs2  = x.u2;
    flush        = x.fl;
    hold         = x.ho;
  endtask

  task automatic set_id(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic v, input logic wr, input logic u2);
    rs1          = a;
    rs2          = b;
    rd           = d;
    id_valid     = v;
    id_reg_write = wr;
    id_mem_read  = 1'b0;
    id_uses_rs2  = u2;
    flush        = 1'b0;
    hold         = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic pc, input logic ifid,
                            input logic bub, input logic [15:0] cnt);
    chk({tag, " PC_write"},     {15'd0, pc_write},     {15'd0, pc});
    chk({tag, " IF_ID_write"},  {15'd0, if_id_write},  {15'd0, ifid});
    chk({tag, " ID_EX_bubble"}, {15'd0, id_ex_bubble}, {15'd0, bub});
    chk({tag, " stall_count"},  stall_count,           cnt);
  endtask

  initial begin
    //           rs1    rs2    rd     v     wr    ld    u2    fl    ho    pc    ifid  bub   cnt
    vt[0]  = '{5'd1,  5'd2,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}; // add x5 issues
    vt[1]  = '{5'd5,  5'd3,  5'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0}; // sub uses x5: stall
    vt[2]  = '{5'd5,  5'd3,  5'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1}; // stall clears
    vt[3]  = '{5'd2,  5'd0,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1}; // lw x7
    vt[4]  = '{5'd1,  5'd7,  5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1}; // load-use on rs2
    vt[5]  = '{5'd1,  5'd7,  5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    vt[6]  = '{5'd1,  5'd8,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // rs2 field unused
    vt[7]  = '{5'd1,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // addi x0
    vt[8]  = '{5'd0,  5'd0,  5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // reads x0: no stall
    vt[9]  = '{5'd1,  5'd2,  5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // independent
    vt[10] = '{5'd10, 5'd3,  5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // MEM producer
    vt[11] = '{5'd12, 5'd0,  5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2}; // flush over hazard
    vt[12] = '{5'd12, 5'd0,  5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // EX invalid after flush
    vt[13] = '{5'd13, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // ID not valid
    vt[14] = '{5'd1,  5'd0,  5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // non-writer x14
    vt[15] = '{5'd14, 5'd14, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2}; // wr=0: no stall
    vt[16] = '{5'd0,  5'd15, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2}; // rs2 hazard
    vt[17] = '{5'd0,  5'd15, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
    vt[18] = '{5'd16, 5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3}; // hold 1
    vt[19] = '{5'd16, 5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3}; // hold 2
    vt[20] = '{5'd16, 5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3}; // hold 3
    vt[21] = '{5'd16, 5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3}; // stall after hold
    vt[22] = '{5'd16, 5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4};
    vt[23] = '{5'd17, 5'd0,  5'd18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4}; // flush under hold
    vt[24] = '{5'd17, 5'd0,  5'd18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4}; // EX kept by hold
    vt[25] = '{5'd17, 5'd0,  5'd18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5};

    // Reset state, including flush/hold gating while in reset.
    rst = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outs("reset", 1'b1, 1'b1, 1'b0, 16'd0);
    flush = 1'b1;
    #1;
    check_outs("reset_flush", 1'b1, 1'b1, 1'b1, 16'd0);
    flush = 1'b0;
    hold  = 1'b1;
    #1;
    check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 16'd0);
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table: one vector per cycle, outputs checked before the edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check_outs($sformatf("row%0d", i), vt[i].pc, vt[i].ifid, vt[i].bub, vt[i].cnt);
    end

    // Asynchronous reset asserted mid-stall, between clock edges.
    @(negedge clk);
    set_id(5'd1, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0);        // producer x20 issues
    @(negedge clk);
    set_id(5'd20, 5'd0, 5'd21, 1'b1, 1'b1, 1'b0);       // consumer of x20
    #1;
    check_outs("pre_rst_stall", 1'b0, 1'b0, 1'b1, 16'd5);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 1'b1, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("post_rst_same_id", 1'b1, 1'b1, 1'b0, 16'd0);
    @(negedge clk);                                     // x21 issued on first edge after release
    set_id(5'd21, 5'd0, 5'd22, 1'b1, 1'b1, 1'b0);
    #1;
    check_outs("first_edge_issue", 1'b0, 1'b0, 1'b1, 16'd0);
    @(negedge clk);
    #1;
    chk("first_edge_count", stall_count, 16'd1);

    // Saturation: preload the counter near the top, then keep stalling.
    @(negedge clk);
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    hold = 1'b1;
    force dut.stall_count_r = 16'hFFFB;
    @(negedge clk);
    release dut.stall_count_r;
    #1;
    chk("preload", stall_count, 16'hFFFB);
    set_id(5'd25, 5'd0, 5'd25, 1'b1, 1'b1, 1'b0);       // self-dependent: stalls every other cycle
    repeat (14) @(negedge clk);
    #1;
    chk("saturate", stall_count, 16'hFFFF);
    repeat (6) @(negedge clk);
    #1;
    chk("saturate_hold", stall_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
